if_exe_pipe_stage: RTL

//  Parametrised IF->EXE boundary register for the three-stage pipeline. Carries instruction + PC

---
 rtl/if_exe_pipe_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/if_exe_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : if_exe_pipe_stage                                           |
// | Description: IF->EXE boundary register with valid/ready handshake,       |
// |              2-entry skid buffer, flush-to-bubble and a programmable     |
// |              reset PC. Optional stall/flush counters are enabled by      |
// |              defining IF_EXE_STATS_EN.                                   |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module if_exe_pipe_stage #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out
`ifdef IF_EXE_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  // Main entry drives the outputs directly; the skid entry catches the one
  // extra word fetch can send before it sees in_ready fall.
  logic            r_main_valid;
  logic [ILEN-1:0] r_main_instr;
  logic [XLEN-1:0] r_main_pc;
  logic            r_skid_valid;
  logic [ILEN-1:0] r_skid_instr;
  logic [XLEN-1:0] r_skid_pc;

  logic w_accept;
  logic w_consume;
  logic w_main_free;

  // in_ready depends only on state, so there is no path from out_ready.
  assign w_accept    = in_valid && !r_skid_valid;
  assign w_consume   = r_main_valid && out_ready;
  assign w_main_free = !r_main_valid || w_consume;

  // Main/skid entry update: reset, flush, then FIFO-ordered handshake moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= pc_rst;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
    end else if (flush) begin
      // Bubble out; PC keeps its last value so EXE still sees a sane PC.
      r_main_valid <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // Skid is older than anything new; in_ready is low so nothing new
        // can arrive in the same cycle.
        r_main_valid <= 1'b1;
        r_main_instr <= r_skid_instr;
        r_main_pc    <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_instr <= in_instr;
        r_main_pc    <= in_pc;
      end else begin
        r_main_valid <= 1'b0;
        r_main_instr <= NOP_INSTR;
      end
    end else if (w_accept) begin
      // Main is held by EXE backpressure: park the new word in the skid.
      r_skid_valid <= 1'b1;
      r_skid_instr <= in_instr;
      r_skid_pc    <= in_pc;
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign instr_out = r_main_instr;
  assign pc_out    = r_main_pc;

`ifdef IF_EXE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating counters of stalled output cycles and flush requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_main_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
